bus_dispatch_1x4: RTL and testbench

- Sequential counterpart of the 4-way byte select path on the CPU internal bus.
- Accepts one byte per cycle from a single source with a valid/ready handshake and a 2-bit destination select.
- Buffers each byte in a small per-destination FIFO and presents it on one of four independently handshaken output ports (register file, ALU operand, memory write, I/O).
- Per-destination ordering is preserved. There is no ordering relation between destinations.

---
 rtl/bus_dispatch_pkg.sv | 21 ++
 rtl/bus_dispatch_1x4_fifo.sv | 69 ++++++
 rtl/bus_dispatch_1x4.sv | 66 ++++++
 tb/tb_bus_dispatch_1x4.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_dispatch_pkg.sv
// Shared constants and helpers for the 1-to-4 byte dispatcher on the CPU internal bus.
package bus_dispatch_pkg;

  localparam int NUM_PORTS      = 4;
  localparam int SEL_W          = 2;
  localparam int DATA_W_DEFAULT = 8;

  typedef enum logic [SEL_W-1:0] {
    PORT_REG = 2'd0,
    PORT_ALU = 2'd1,
    PORT_MEM = 2'd2,
    PORT_IO  = 2'd3
  } port_e;

  function automatic logic [NUM_PORTS-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    logic [NUM_PORTS-1:0] one;
    one = {{(NUM_PORTS-1){1'b0}}, 1'b1};
    return one << sel;
  endfunction

endpackage

// File: rtl/bus_dispatch_1x4_fifo.sv
// Per-destination byte FIFO: registered storage, head entry always visible on rdata.
module byte_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push_s, do_pop_s;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == {CNT_W{1'b0}});
  assign rdata     = mem_q[rd_ptr_q];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Next-state: pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers; storage clears on reset so out_data reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/bus_dispatch_1x4.sv
// 1-to-4 byte dispatcher with per-destination FIFOs.
// Optional broadcast input enabled by defining BUS_DISPATCH_BCAST_EN.
module bus_dispatch_1x4
  import bus_dispatch_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int DEPTH  = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_data,
  input  logic [SEL_W-1:0]            in_sel,
`ifdef BUS_DISPATCH_BCAST_EN
  input  logic                        in_bcast,
`endif
  output logic [NUM_PORTS-1:0]        out_valid,
  input  logic [NUM_PORTS-1:0]        out_ready,
  output logic [NUM_PORTS*DATA_W-1:0] out_data,
  output logic                        busy
);

  logic [NUM_PORTS-1:0] full_s, empty_s, push_s, pop_s;
  logic                 uni_ready_s;

  assign uni_ready_s = !full_s[in_sel];

  // Push decode: a full target blocks acceptance even if it pops this cycle.
  always_comb begin
    in_ready = uni_ready_s;
    push_s   = {NUM_PORTS{1'b0}};
`ifdef BUS_DISPATCH_BCAST_EN
    if (in_bcast) begin
      in_ready = ~|full_s;
      push_s   = {NUM_PORTS{in_valid && (~|full_s)}};
    end else begin
      in_ready = uni_ready_s;
      push_s   = sel_onehot(in_sel) & {NUM_PORTS{in_valid && uni_ready_s}};
    end
`else
    push_s = sel_onehot(in_sel) & {NUM_PORTS{in_valid && uni_ready_s}};
`endif
  end

  assign out_valid = ~empty_s;
  assign pop_s     = out_valid & out_ready;
  assign busy      = |out_valid;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_fifo
    byte_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_s[i]),
      .pop   (pop_s[i]),
      .wdata (in_data),
      .rdata (out_data[i*DATA_W +: DATA_W]),
      .full  (full_s[i]),
      .empty (empty_s[i])
    );
  end

endmodule

// File: tb/tb_bus_dispatch_1x4.sv
// Self-checking bench for bus_dispatch_1x4 against a queue-based reference model.
module tb_bus_dispatch_1x4;

  localparam int DEPTH = 2;
  localparam int NP    = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
`ifdef BUS_DISPATCH_BCAST_EN
  logic        in_bcast;
`endif
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_data;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mq [NP][$];

  bus_dispatch_1x4 #(.DATA_W(8), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
`ifdef BUS_DISPATCH_BCAST_EN
    .in_bcast  (in_bcast),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [3:0] m_valid();
    logic [3:0] v;
    v = 4'b0000;
    for (int i = 0; i < NP; i++) v[i] = (mq[i].size() != 0);
    return v;
  endfunction

  function automatic logic m_ready();
`ifdef BUS_DISPATCH_BCAST_EN
    if (in_bcast) begin
      for (int i = 0; i < NP; i++) if (mq[i].size() >= DEPTH) return 1'b0;
      return 1'b1;
    end
`endif
    return (mq[in_sel].size() < DEPTH);
  endfunction

  function automatic logic [7:0] slice(input int i);
    return out_data[i*8 +: 8];
  endfunction

  // Advance one clock edge, updating the model from the inputs seen before the edge.
  task automatic clk_step();
    logic       acc, bc;
    logic [1:0] s;
    logic [7:0] d;
    logic [3:0] pops;
    acc = in_valid && m_ready();
    s   = in_sel;
    d   = in_data;
    bc  = 1'b0;
`ifdef BUS_DISPATCH_BCAST_EN
    bc  = in_bcast;
`endif
    for (int i = 0; i < NP; i++) pops[i] = (mq[i].size() != 0) && out_ready[i];
    @(posedge clk);
    for (int i = 0; i < NP; i++) if (pops[i]) void'(mq[i].pop_front());
    if (acc) begin
      if (bc) begin
        for (int i = 0; i < NP; i++) mq[i].push_back(d);
      end else begin
        mq[s].push_back(d);
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    in_sel    = 2'd0;
    in_data   = 8'h00;
    out_ready = 4'b0000;
`ifdef BUS_DISPATCH_BCAST_EN
    in_bcast  = 1'b0;
`endif
  endtask

  task automatic drain();
    idle_inputs();
    out_ready = 4'b1111;
    for (int k = 0; k < DEPTH + 1; k++) clk_step();
    out_ready = 4'b0000;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #3;
    checks++;
    if (out_valid !== 4'b0000 || out_data !== 32'h0 || in_ready !== 1'b1 || busy !== 1'b0)
      begin failures++; $display("FAIL reset_init: valid=%b data=%h rdy=%b busy=%b", out_valid, out_data, in_ready, busy); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1; in_sel = 2'd2; in_data = 8'h5A;
    clk_step();
    idle_inputs();
    #1;
    checks++;
    if (out_valid !== 4'b0100 || slice(2) !== 8'h5A || busy !== 1'b1)
      begin failures++; $display("FAIL reset_preload: valid=%b data=%h want 0100/5a", out_valid, slice(2)); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 4'b0000 || out_data !== 32'h0 || in_ready !== 1'b1 || busy !== 1'b0)
      begin failures++; $display("FAIL reset_mid: valid=%b data=%h rdy=%b busy=%b", out_valid, out_data, in_ready, busy); end
    for (int i = 0; i < NP; i++) mq[i].delete();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_routing();
    logic [7:0] bytes [4];
    logic [3:0] want;
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_sel = 2'(k); in_data = bytes[k];
      #1;
      checks++;
      if (out_valid !== (4'b1111 >> (4 - k)))
        begin failures++; $display("FAIL route_latency%0d: valid=%b before edge", k, out_valid); end
      clk_step();
      want = 4'b1111 >> (3 - k);
      checks++;
      if (out_valid !== want)
        begin failures++; $display("FAIL route_valid%0d: got %b want %b", k, out_valid, want); end
    end
    idle_inputs();
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (slice(k) !== bytes[k])
        begin failures++; $display("FAIL route_data%0d: got %h want %h", k, slice(k), bytes[k]); end
    end
    drain();
  endtask

  task automatic test_full();
    logic [7:0] got [$];
    idle_inputs();
    in_valid = 1'b1; in_sel = 2'd1;
    in_data = 8'hA0; clk_step();
    in_data = 8'hA1; clk_step();
    in_data = 8'hA2; #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL full_stall: in_ready=%b want 0", in_ready); end
    in_valid = 1'b0; in_sel = 2'd3; #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL full_other: in_ready=%b want 1", in_ready); end
    in_valid = 1'b1; in_sel = 2'd1; out_ready = 4'b0010; #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL full_no_passthru: in_ready=%b want 0", in_ready); end
    got.push_back(slice(1));
    clk_step();
    out_ready = 4'b0000; #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL full_after_pop: in_ready=%b want 1", in_ready); end
    clk_step();
    in_valid = 1'b0; out_ready = 4'b0010;
    for (int k = 0; k < 2; k++) begin
      #1; got.push_back(slice(1)); clk_step();
    end
    out_ready = 4'b0000;
    checks++;
    if (got.size() != 3 || got[0] !== 8'hA0 || got[1] !== 8'hA1 || got[2] !== 8'hA2)
      begin failures++; $display("FAIL full_order: got %p want A0 A1 A2", got); end
    checks++;
    if (out_valid[1] !== 1'b0) begin failures++; $display("FAIL full_drained: valid1=%b want 0", out_valid[1]); end
    drain();
  endtask

  task automatic test_push_pop();
    idle_inputs();
    in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h01; clk_step();
    in_data = 8'h02; out_ready = 4'b0001; #1;
    checks++;
    if (slice(0) !== 8'h01 || in_ready !== 1'b1)
      begin failures++; $display("FAIL pp_head: data=%h rdy=%b want 01/1", slice(0), in_ready); end
    clk_step();
    in_valid = 1'b0; out_ready = 4'b0000; #1;
    checks++;
    if (out_valid[0] !== 1'b1 || slice(0) !== 8'h02)
      begin failures++; $display("FAIL pp_next: valid=%b data=%h want 1/02", out_valid[0], slice(0)); end
    out_ready = 4'b0001; clk_step();
    out_ready = 4'b0000; #1;
    checks++;
    if (out_valid[0] !== 1'b0)
      begin failures++; $display("FAIL pp_count: valid0=%b want 0 after one pop", out_valid[0]); end
  endtask

  task automatic test_wrap();
    int sent, recv, cyc;
    idle_inputs();
    sent = 0; recv = 0; cyc = 0;
    while (recv < 10 && cyc < 300) begin
      in_valid = (sent < 10); in_sel = 2'd3; in_data = 8'(sent);
      out_ready = {1'($urandom_range(0, 1)), 3'b000};
      #1;
      if (out_valid[3] && out_ready[3]) begin
        checks++;
        if (slice(3) !== 8'(recv))
          begin failures++; $display("FAIL wrap_data: got %h want %h", slice(3), 8'(recv)); end
        recv++;
      end
      if (in_valid && in_ready) sent++;
      clk_step();
      cyc++;
    end
    checks++;
    if (recv != 10) begin failures++; $display("FAIL wrap_count: got %0d want 10", recv); end
    idle_inputs();
    #1;
    checks++;
    if (out_valid[3] !== 1'b0) begin failures++; $display("FAIL wrap_dup: valid3=%b want 0", out_valid[3]); end
  endtask

  task automatic test_random();
    logic hold;
    hold = 1'b0;
    idle_inputs();
    for (int c = 0; c < 400; c++) begin
      if (!hold) begin
        in_valid = 1'($urandom_range(0, 3) != 0);
        in_sel   = 2'($urandom_range(0, 3));
        in_data  = 8'($urandom_range(0, 255));
      end
      out_ready = 4'($urandom_range(0, 15));
      #1;
      checks++;
      if (out_valid !== m_valid() || in_ready !== m_ready() || busy !== (|m_valid()))
        begin failures++; $display("FAIL rand_ctl c=%0d: valid=%b/%b rdy=%b/%b busy=%b", c, out_valid, m_valid(), in_ready, m_ready(), busy); end
      for (int i = 0; i < NP; i++) begin
        if (mq[i].size() != 0) begin
          checks++;
          if (slice(i) !== mq[i][0])
            begin failures++; $display("FAIL rand_data c=%0d p%0d: got %h want %h", c, i, slice(i), mq[i][0]); end
        end
      end
      hold = in_valid && !m_ready();
      clk_step();
    end
    drain();
  endtask

`ifdef BUS_DISPATCH_BCAST_EN
  task automatic test_bcast();
    idle_inputs();
    in_valid = 1'b1; in_sel = 2'd2;
    in_data = 8'hB0; clk_step();
    in_data = 8'hB1; clk_step();
    in_bcast = 1'b1; in_sel = 2'd0; in_data = 8'hFF; #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL bcast_full: in_ready=%b want 0", in_ready); end
    out_ready = 4'b0100; clk_step();
    out_ready = 4'b0000; #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL bcast_ready: in_ready=%b want 1", in_ready); end
    clk_step();
    idle_inputs(); #1;
    for (int i = 0; i < NP; i++) if (i != 2) begin
      checks++;
      if (out_valid[i] !== 1'b1 || slice(i) !== 8'hFF)
        begin failures++; $display("FAIL bcast_port%0d: valid=%b data=%h want 1/ff", i, out_valid[i], slice(i)); end
    end
    out_ready = 4'b0100; clk_step();
    out_ready = 4'b0000; #1;
    checks++;
    if (out_valid[2] !== 1'b1 || slice(2) !== 8'hFF)
      begin failures++; $display("FAIL bcast_tail2: valid=%b data=%h want 1/ff", out_valid[2], slice(2)); end
    drain();
  endtask
`endif

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_routing();
    test_full();
    test_push_pop();
    test_wrap();
`ifdef BUS_DISPATCH_BCAST_EN
    test_bcast();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
